// File: rtl/tcu_wmma_sequencer_pkg.sv
// Shared TCU constants and types for the WMMA micro-op sequencer.
// Holds the step geometry, register bases, format ids, the micro-op
// record layout and the sequencer state encoding.
package tcu_wmma_sequencer_pkg;

   localparam int TCU_M_STEPS = 4;
   localparam int TCU_N_STEPS = 2;
   localparam int TCU_K_STEPS = 2;
   localparam int TCU_UOPS    = TCU_M_STEPS * TCU_N_STEPS * TCU_K_STEPS;

   localparam int TCU_RA = 0;
   localparam int TCU_RB = 28;
   localparam int TCU_RC = 10;

   localparam logic [3:0] TCU_FMT_FP32 = 4'd0;
   localparam logic [3:0] TCU_FMT_FP16 = 4'd1;
   localparam logic [3:0] TCU_FMT_BF16 = 4'd2;
   localparam logic [3:0] TCU_FMT_I8   = 4'd3;

   // Counter width for a step dimension; a single step still needs one bit.
   function automatic int step_bits(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } tcu_seq_state_e;

   typedef struct packed {
      logic [step_bits(TCU_M_STEPS)-1:0] step_m;
      logic [step_bits(TCU_N_STEPS)-1:0] step_n;
      logic [step_bits(TCU_K_STEPS)-1:0] step_k;
      logic [4:0]                        rs1;
      logic [4:0]                        rs2;
      logic [4:0]                        rs3;
      logic                              first;
      logic                              last;
   } tcu_uop_t;

endpackage

// File: rtl/tcu_wmma_sequencer_step_counter.sv
// tcu_step_counter: three-level nested wrap counter (k innermost, then n,
// then m).
// Ports: clk, reset (sync, active-low), clear (zero all levels, wins over
// advance), advance (step once), m/n/k (current step), is_first (all zero),
// is_last (all at maximum).
module tcu_step_counter
   import tcu_wmma_sequencer_pkg::*;
#(
   parameter  int M_STEPS = 4,
   parameter  int N_STEPS = 2,
   parameter  int K_STEPS = 2,
   localparam int SM      = step_bits(M_STEPS),
   localparam int SN      = step_bits(N_STEPS),
   localparam int SK      = step_bits(K_STEPS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          advance,
   output logic [SM-1:0] m,
   output logic [SN-1:0] n,
   output logic [SK-1:0] k,
   output logic          is_first,
   output logic          is_last
);

   logic m_max, n_max, k_max;

   assign m_max = (m == SM'(M_STEPS - 1));
   assign n_max = (n == SN'(N_STEPS - 1));
   assign k_max = (k == SK'(K_STEPS - 1));

   assign is_first = (m == '0) && (n == '0) && (k == '0);
   assign is_last  = m_max && n_max && k_max;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         m <= '0;
         n <= '0;
         k <= '0;
      end else if (advance) begin
         if (k_max) begin
            k <= '0;
            if (n_max) begin
               n <= '0;
               m <= m_max ? '0 : m + SM'(1);
            end else begin
               n <= n + SN'(1);
            end
         end else begin
            k <= k + SK'(1);
         end
      end
   end

endmodule

// File: rtl/tcu_wmma_sequencer.sv
// tcu_wmma_sequencer: expands one accepted WMMA instruction into
// M_STEPS*N_STEPS*K_STEPS tensor-core micro-ops, one per out handshake.
// Ports: clk, reset (sync, active-low), flush (abort current instruction);
// in_valid/in_ready with in_wid, in_uuid, in_fmt_s, in_fmt_d (instruction);
// out_valid/out_ready with latched out_wid/out_uuid/out_fmt_s/out_fmt_d,
// out_step_m/n/k, out_rs1/2/3 (A/B/C register indices), out_first, out_last;
// busy (instruction in progress).
module tcu_wmma_sequencer
   import tcu_wmma_sequencer_pkg::*;
#(
   parameter  int NW_BITS    = 2,
   parameter  int UUID_WIDTH = 44,
   parameter  int M_STEPS    = 4,
   parameter  int N_STEPS    = 2,
   parameter  int K_STEPS    = 2,
   parameter  int RA         = 0,
   parameter  int RB         = 28,
   parameter  int RC         = 10,
   localparam int SM         = step_bits(M_STEPS),
   localparam int SN         = step_bits(N_STEPS),
   localparam int SK         = step_bits(K_STEPS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NW_BITS-1:0]    in_wid,
   input  logic [UUID_WIDTH-1:0] in_uuid,
   input  logic [3:0]            in_fmt_s,
   input  logic [3:0]            in_fmt_d,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NW_BITS-1:0]    out_wid,
   output logic [UUID_WIDTH-1:0] out_uuid,
   output logic [3:0]            out_fmt_s,
   output logic [3:0]            out_fmt_d,
   output logic [SM-1:0]         out_step_m,
   output logic [SN-1:0]         out_step_n,
   output logic [SK-1:0]         out_step_k,
   output logic [4:0]            out_rs1,
   output logic [4:0]            out_rs2,
   output logic [4:0]            out_rs3,
   output logic                  out_first,
   output logic                  out_last,
   output logic                  busy
);

   localparam int MAX_RS1 = RA + (M_STEPS - 1) * K_STEPS + (K_STEPS - 1);
   localparam int MAX_RS2 = RB + (N_STEPS - 1) * K_STEPS + (K_STEPS - 1);
   localparam int MAX_RS3 = RC + (M_STEPS - 1) * N_STEPS + (N_STEPS - 1);

   // Register indices are 5 bits wide; reject geometries that would wrap.
   generate
      if (MAX_RS1 > 31 || MAX_RS2 > 31 || MAX_RS3 > 31) begin : g_idx_range
         $error("tcu_wmma_sequencer: register index exceeds 31");
      end
   endgenerate

   tcu_seq_state_e state, state_next;
   logic hs, last_hs, accept;

   assign out_valid = (state == ISSUE);
   assign busy      = (state == ISSUE);
   assign hs        = out_valid && out_ready;
   assign last_hs   = hs && out_last;
   // Accepting on the last handshake gives zero-bubble back-to-back issue.
   assign in_ready  = !flush && ((state == IDLE) || last_hs);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IDLE;
      end else if (accept) begin
         state_next = ISSUE;
      end else if (last_hs) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_wid   <= '0;
         out_uuid  <= '0;
         out_fmt_s <= '0;
         out_fmt_d <= '0;
      end else if (accept) begin
         out_wid   <= in_wid;
         out_uuid  <= in_uuid;
         out_fmt_s <= in_fmt_s;
         out_fmt_d <= in_fmt_d;
      end
   end

   tcu_step_counter #(
      .M_STEPS (M_STEPS),
      .N_STEPS (N_STEPS),
      .K_STEPS (K_STEPS)
   ) u_step_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept || flush),
      .advance  (hs),
      .m        (out_step_m),
      .n        (out_step_n),
      .k        (out_step_k),
      .is_first (out_first),
      .is_last  (out_last)
   );

   assign out_rs1 = 5'(RA) + 5'(out_step_m) * 5'(K_STEPS) + 5'(out_step_k);
   assign out_rs2 = 5'(RB) + 5'(out_step_n) * 5'(K_STEPS) + 5'(out_step_k);
   assign out_rs3 = 5'(RC) + 5'(out_step_m) * 5'(N_STEPS) + 5'(out_step_n);

endmodule
